hamming_secded_codec: RTL and testbench
=======================================

HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 SHALL have parameter K, default 4: data bits per codeword, legal range 4..26.
REQ-002 SHALL derive R as the smallest value with 2^R >= K+R+1, and N = K+R+1 (8 for K=4); both are localparams, not overridable.
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  global advance; low = stall
- enc_in  input  1  serial data bit to encoder
- enc_valid  input  1  enc_in qualifier
- enc_ready  output  1  encoder accepts a bit this cycle
- inject_mask  input  N  error-injection mask, bit i flips codeword position i
- enc_out  output  1  serial codeword bit
- enc_out_valid  output  1  enc_out qualifier
- dec_in  input  1  serial codeword bit to decoder
- dec_valid  input  1  dec_in qualifier
- dec_ready  output  1  decoder accepts a bit this cycle
- dec_out  output  1  serial corrected data bit
- dec_out_valid  output  1  dec_out qualifier
- syndrome  output  R  last computed syndrome
- err_corrected  output  1  one-cycle pulse, single error corrected
- err_uncorrectable  output  1  one-cycle pulse, double/invalid error
- corr_cnt  output  8  corrected-error count, saturating
- uncorr_cnt  output  8  uncorrectable-error count, saturating

Function
REQ-004 SHALL use codeword positions 0..N-1: parity bits at positions 1,2,4,...,2^(R-1); data at the remaining positions 3..N-1 in ascending order, first serial data bit at the lowest position; position 0 = overall parity (XOR of positions 1..N-1).
REQ-005 SHALL compute parity at position 2^j as the XOR of all positions 1..N-1 whose index has bit j set.
REQ-006 SHALL transmit and receive codewords in order: position 1 first through N-1, then position 0 last.
REQ-007 SHALL run the encoder FSM COLLECT -> SHIFT -> COLLECT: in COLLECT, enc_ready=1 and a bit is accepted when enc_valid=1 and enable=1.
REQ-008 SHALL, on acceptance of the K-th bit at cycle t, latch the codeword XOR inject_mask (mask sampled at t) and drive enc_out_valid=1 from t+1 through t+N.
REQ-009 SHALL hold enc_ready=0 during SHIFT, ignore enc_valid there, and reassert enc_ready at t+N+1.
REQ-010 SHALL run the decoder FSM COLLECT -> CHECK -> SHIFT -> COLLECT: dec_ready=1 only in COLLECT; a bit is accepted when dec_valid=1 and enable=1.
REQ-011 SHALL, after the N-th bit is accepted at cycle t, spend cycle t+1 in CHECK computing S (XOR of indices of set bits 1..N-1) and P (XOR of all N bits).
REQ-012 SHALL, at t+2, update syndrome, pulse flags, update counters, and start output of K data bits on dec_out with dec_out_valid=1 for t+2..t+K+1; dec_ready reasserts at t+K+2.
REQ-013 SHALL classify and correct as follows:
- S=0, P=0: no error, no flag
- P=1 and S<=N-1: flip position S (S=0 = overall parity bit only), err_corrected pulse
- P=0 and S!=0, or P=1 and S>N-1: err_uncorrectable pulse, data output uncorrected
REQ-014 SHALL saturate corr_cnt and uncorr_cnt at 255; no wrap.
REQ-015 SHALL, while enable=0, freeze all FSM state, shift registers and counters, force enc_out_valid, dec_out_valid, err_corrected and err_uncorrectable to 0, and resume the same bit when enable returns to 1.
REQ-016 SHALL operate the encoder and decoder independently; simultaneous activity on both paths, including loopback of enc_out to dec_in, is legal.

Reset
REQ-017 SHALL, when reset=1 at a clock edge, return both FSMs to COLLECT with bit counts zero; reset overrides enable and any mid-codeword operation, discarding partial words.
REQ-018 SHALL drive these values out of reset: enc_ready=1, dec_ready=1, all other outputs 0 (syndrome=0, counters=0).

Verification
REQ-019 SHALL cover: K=4, inject_mask=0, enc_in 1,0,1,1 -> enc_out 0,1,1,0,0,1,1,0 on 8 consecutive valid cycles.
REQ-020 SHALL cover: loopback, data 1011, inject_mask=8'b0010_0000 (position 5) -> dec_out 1,0,1,1, syndrome=5, err_corrected pulse, corr_cnt=1.
REQ-021 SHALL cover: loopback, inject_mask flips positions 3 and 6 -> syndrome=5, err_uncorrectable pulse, uncorr_cnt=1, dec_out = received (uncorrected) data.
REQ-022 SHALL cover: inject_mask flips position 0 only -> syndrome=0, err_corrected pulse, dec_out 1,0,1,1.
REQ-023 SHALL cover: reset asserted after 2 decoder bits -> dec_ready=1 next cycle; the next full 8-bit codeword decodes correctly.
REQ-024 SHALL cover: enable low for 3 cycles mid-SHIFT -> enc_out_valid=0 for those cycles, codeword resumes unbroken; 256 corrected errors -> corr_cnt holds at 255.

Source files
------------

// File: rtl/hamming_secded_codec.sv
// rtl/hamming_secded_codec.sv - serial Hamming SECDED encoder/decoder pair
//
// Purpose: a serial encoder turns K data bits into an N-bit extended Hamming
// codeword, and a serial decoder turns N-bit codewords back into corrected
// data. The two paths share only clk, reset and enable.
//
// Codeword layout: parity bits sit at positions 1,2,4,...; data bits sit at
// the other positions from 3 upward, with the first serial data bit lowest.
// Position 0 holds the overall parity. Bits go out and come in as position
// 1 first, up to N-1, and position 0 last.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   enable              global advance; low stalls everything and masks pulses
//   enc_in/enc_valid    serial data into the encoder; enc_ready = accepting
//   inject_mask         XORed into the codeword when the K-th bit is accepted
//   enc_out/_valid      serial codeword out
//   dec_in/dec_valid    serial codeword into the decoder; dec_ready = accepting
//   dec_out/_valid      serial corrected data out
//   syndrome            syndrome of the last checked codeword
//   err_corrected       one-cycle pulse, single error corrected
//   err_uncorrectable   one-cycle pulse, double or invalid error
//   corr_cnt/uncorr_cnt saturating error counters
module hamming_secded_codec #(
  parameter int K = 4,
  // Smallest R with 2^R >= K+R+1, written out for the supported range of K.
  localparam int R = (K <= 1) ? 2 : (K <= 4) ? 3 : (K <= 11) ? 4 : (K <= 26) ? 5 : 6,
  localparam int N = K + R + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         enc_in,
  input  logic         enc_valid,
  output logic         enc_ready,
  input  logic [N-1:0] inject_mask,
  output logic         enc_out,
  output logic         enc_out_valid,
  input  logic         dec_in,
  input  logic         dec_valid,
  output logic         dec_ready,
  output logic         dec_out,
  output logic         dec_out_valid,
  output logic [R-1:0] syndrome,
  output logic         err_corrected,
  output logic         err_uncorrectable,
  output logic [7:0]   corr_cnt,
  output logic [7:0]   uncorr_cnt
);

  localparam logic [0:0] ENC_COLLECT = 1'b0;
  localparam logic [0:0] ENC_SHIFT   = 1'b1;

  localparam logic [1:0] DEC_COLLECT = 2'd0;
  localparam logic [1:0] DEC_CHECK   = 2'd1;
  localparam logic [1:0] DEC_SHIFT   = 2'd2;

  // Builds the codeword indexed by position from the data bits.
  function automatic logic [N-1:0] encode(input logic [K-1:0] data);
    logic [N-1:0] w;
    int k;
    w = '0;
    k = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = data[k];
        k++;
      end
    end
    for (int j = 0; j < R; j++) begin
      for (int p = 1; p < N; p++) begin
        if ((((p >> j) & 1) != 0) && (p != (1 << j))) begin
          w[1 << j] = w[1 << j] ^ w[p];
        end
      end
    end
    w[0] = ^w[N-1:1];
    return w;
  endfunction

  // Pulls the data bits back out of a position-indexed codeword.
  function automatic logic [K-1:0] extract(input logic [N-1:0] w);
    logic [K-1:0] data;
    int k;
    data = '0;
    k = 0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[k] = w[p];
        k++;
      end
    end
    return data;
  endfunction

  // ---------------- encoder ----------------
  logic [0:0]   enc_state_q, enc_state_d;
  logic [5:0]   enc_cnt_q, enc_cnt_d;
  logic [K-1:0] enc_data_q, enc_data_d;
  logic [N-1:0] enc_sr_q, enc_sr_d;
  logic [N-1:0] enc_word;

  always_comb begin
    enc_state_d = enc_state_q;
    enc_cnt_d   = enc_cnt_q;
    enc_data_d  = enc_data_q;
    enc_sr_d    = enc_sr_q;
    enc_word    = '0;
    if (enable) begin
      case (enc_state_q)
        ENC_COLLECT: begin
          if (enc_valid) begin
            // Shift in from the top so the first bit ends up in data[0].
            enc_data_d = {enc_in, enc_data_q[K-1:1]};
            if (enc_cnt_q == 6'(K - 1)) begin
              enc_word    = encode(enc_data_d) ^ inject_mask;
              // Transmit order: positions 1..N-1, then position 0.
              enc_sr_d    = {enc_word[0], enc_word[N-1:1]};
              enc_cnt_d   = '0;
              enc_state_d = ENC_SHIFT;
            end else begin
              enc_cnt_d = enc_cnt_q + 6'd1;
            end
          end
        end
        default: begin
          enc_sr_d = {1'b0, enc_sr_q[N-1:1]};
          if (enc_cnt_q == 6'(N - 1)) begin
            enc_cnt_d   = '0;
            enc_state_d = ENC_COLLECT;
          end else begin
            enc_cnt_d = enc_cnt_q + 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_state_q <= ENC_COLLECT;
      enc_cnt_q   <= '0;
      enc_data_q  <= '0;
      enc_sr_q    <= '0;
    end else begin
      enc_state_q <= enc_state_d;
      enc_cnt_q   <= enc_cnt_d;
      enc_data_q  <= enc_data_d;
      enc_sr_q    <= enc_sr_d;
    end
  end

  assign enc_ready     = (enc_state_q == ENC_COLLECT);
  assign enc_out_valid = (enc_state_q == ENC_SHIFT) && enable;
  assign enc_out       = enc_out_valid && enc_sr_q[0];

  // ---------------- decoder ----------------
  logic [1:0]   dec_state_q, dec_state_d;
  logic [5:0]   dec_cnt_q, dec_cnt_d;
  logic [N-1:0] rx_sr_q, rx_sr_d;
  logic [K-1:0] dout_sr_q, dout_sr_d;
  logic [R-1:0] syn_q, syn_d;
  logic         corr_q, corr_d;
  logic         uncorr_q, uncorr_d;
  logic [7:0]   corr_cnt_q, corr_cnt_d;
  logic [7:0]   uncorr_cnt_q, uncorr_cnt_d;
  logic [N-1:0] rx_word;
  logic [R-1:0] s_calc;
  logic         p_calc;

  // Received shift register is in transmit order; re-index it by position.
  assign rx_word = {rx_sr_q[N-2:0], rx_sr_q[N-1]};

  always_comb begin
    s_calc = '0;
    for (int p = 1; p < N; p++) begin
      if (rx_word[p]) begin
        s_calc = s_calc ^ R'(p);
      end
    end
    p_calc = ^rx_word;
  end

  always_comb begin
    logic [N-1:0] fixed;
    dec_state_d  = dec_state_q;
    dec_cnt_d    = dec_cnt_q;
    rx_sr_d      = rx_sr_q;
    dout_sr_d    = dout_sr_q;
    syn_d        = syn_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    fixed        = rx_word;
    if (enable) begin
      // Flags last exactly one advancing cycle.
      corr_d   = 1'b0;
      uncorr_d = 1'b0;
      case (dec_state_q)
        DEC_COLLECT: begin
          if (dec_valid) begin
            rx_sr_d = {dec_in, rx_sr_q[N-1:1]};
            if (dec_cnt_q == 6'(N - 1)) begin
              dec_cnt_d   = '0;
              dec_state_d = DEC_CHECK;
            end else begin
              dec_cnt_d = dec_cnt_q + 6'd1;
            end
          end
        end
        DEC_CHECK: begin
          syn_d = s_calc;
          if (p_calc && (32'(s_calc) <= 32'(N - 1))) begin
            // Odd overall parity and a syndrome naming a real position:
            // single error there (syndrome 0 means the overall parity bit).
            for (int p = 0; p < N; p++) begin
              if (32'(s_calc) == 32'(p)) begin
                fixed[p] = ~rx_word[p];
              end
            end
            corr_d = 1'b1;
            if (corr_cnt_q != 8'hFF) begin
              corr_cnt_d = corr_cnt_q + 8'd1;
            end
          end else if (p_calc || (s_calc != '0)) begin
            uncorr_d = 1'b1;
            if (uncorr_cnt_q != 8'hFF) begin
              uncorr_cnt_d = uncorr_cnt_q + 8'd1;
            end
          end
          dout_sr_d   = extract(fixed);
          dec_state_d = DEC_SHIFT;
        end
        default: begin
          dout_sr_d = {1'b0, dout_sr_q[K-1:1]};
          if (dec_cnt_q == 6'(K - 1)) begin
            dec_cnt_d   = '0;
            dec_state_d = DEC_COLLECT;
          end else begin
            dec_cnt_d = dec_cnt_q + 6'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state_q  <= DEC_COLLECT;
      dec_cnt_q    <= '0;
      rx_sr_q      <= '0;
      dout_sr_q    <= '0;
      syn_q        <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      dec_state_q  <= dec_state_d;
      dec_cnt_q    <= dec_cnt_d;
      rx_sr_q      <= rx_sr_d;
      dout_sr_q    <= dout_sr_d;
      syn_q        <= syn_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign dec_ready         = (dec_state_q == DEC_COLLECT);
  assign dec_out_valid     = (dec_state_q == DEC_SHIFT) && enable;
  assign dec_out           = dec_out_valid && dout_sr_q[0];
  assign syndrome          = syn_q;
  assign err_corrected     = corr_q && enable;
  assign err_uncorrectable = uncorr_q && enable;
  assign corr_cnt          = corr_cnt_q;
  assign uncorr_cnt        = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb/tb_hamming_secded_codec.sv - directed vector bench for hamming_secded_codec
module tb_hamming_secded_codec;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       enc_in;
  logic       enc_valid;
  logic       enc_ready;
  logic [7:0] inject_mask;
  logic       enc_out;
  logic       enc_out_valid;
  logic       dec_in_w;
  logic       dec_valid_w;
  logic       dec_ready;
  logic       dec_out;
  logic       dec_out_valid;
  logic [2:0] syndrome;
  logic       err_corrected;
  logic       err_uncorrectable;
  logic [7:0] corr_cnt;
  logic [7:0] uncorr_cnt;

  logic loop_sel;
  logic tb_dec_in;
  logic tb_dec_valid;

  int checks = 0;
  int errors = 0;

  assign dec_in_w    = loop_sel ? enc_out : tb_dec_in;
  assign dec_valid_w = loop_sel ? enc_out_valid : tb_dec_valid;

  always #5 clk = ~clk;

  hamming_secded_codec #(.K(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .enc_in            (enc_in),
    .enc_valid         (enc_valid),
    .enc_ready         (enc_ready),
    .inject_mask       (inject_mask),
    .enc_out           (enc_out),
    .enc_out_valid     (enc_out_valid),
    .dec_in            (dec_in_w),
    .dec_valid         (dec_valid_w),
    .dec_ready         (dec_ready),
    .dec_out           (dec_out),
    .dec_out_valid     (dec_out_valid),
    .syndrome          (syndrome),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .corr_cnt          (corr_cnt),
    .uncorr_cnt        (uncorr_cnt)
  );

  // Bit strings are written in serial order: leftmost bit travels first.
  typedef struct {
    logic [3:0] data;
    logic [7:0] mask;
    logic [7:0] enc;
    logic [3:0] dout;
    logic [2:0] syn;
    int         corr;
    int         uncorr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Shared output monitor: samples at negedges until K decoded bits appear.
  task automatic capture(input int stall_at,
                         output logic [7:0] enc_seq, output int enc_n, output logic enc_gap,
                         output logic [3:0] dout, output int corr_n, output int uncorr_n,
                         output logic [2:0] syn, output logic to, output logic stall_bad,
                         output logic ready_bad);
    int dn;
    int last_c;
    int stall_left;
    logic stalled;
    enc_seq = '0; enc_n = 0; enc_gap = 1'b0; dout = '0; corr_n = 0; uncorr_n = 0;
    syn = '0; to = 1'b0; stall_bad = 1'b0; ready_bad = 1'b0;
    dn = 0; last_c = 0; stall_left = 0; stalled = 1'b0;
    for (int c = 0; c < 80 && dn < 4; c++) begin
      if (stall_left > 0) begin
        if (enc_out_valid || dec_out_valid || err_corrected || err_uncorrectable) stall_bad = 1'b1;
        stall_left--;
        if (stall_left == 0) enable = 1'b1;
      end else begin
        if (enc_out_valid) begin
          if (enc_ready) ready_bad = 1'b1;
          if (enc_n < 8) enc_seq[7 - enc_n] = enc_out;
          if (enc_n > 0 && last_c != c - 1 && stall_at < 0) enc_gap = 1'b1;
          last_c = c;
          enc_n++;
        end
        if (dec_out_valid) begin
          if (dn == 0) syn = syndrome;
          dout[3 - dn] = dec_out;
          dn++;
        end
        if (err_corrected) corr_n++;
        if (err_uncorrectable) uncorr_n++;
        if (stall_at >= 0 && !stalled && enc_n == stall_at) begin
          enable = 1'b0;
          stalled = 1'b1;
          stall_left = 3;
        end
      end
      @(negedge clk);
    end
    if (dn < 4) to = 1'b1;
  endtask

  // Feeds K data bits to the encoder; decoder is looped back from enc_out.
  task automatic run_word(input logic [3:0] data, input logic [7:0] mask, input int stall_at,
                          output logic [7:0] enc_seq, output int enc_n, output logic enc_gap,
                          output logic [3:0] dout, output int corr_n, output int uncorr_n,
                          output logic [2:0] syn, output logic to, output logic stall_bad,
                          output logic ready_bad);
    int waited;
    logic to_in;
    to_in = 1'b0;
    loop_sel = 1'b1;
    inject_mask = mask;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while ((!enc_ready || (i == 0 && !dec_ready)) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) to_in = 1'b1;
      enc_in = data[3 - i];
      enc_valid = 1'b1;
      @(negedge clk);
    end
    enc_valid = 1'b0;
    enc_in = 1'b0;
    capture(stall_at, enc_seq, enc_n, enc_gap, dout, corr_n, uncorr_n, syn, to, stall_bad, ready_bad);
    to = to | to_in;
  endtask

  // Drives a raw 8-bit codeword straight into the decoder.
  task automatic dec_word(input logic [7:0] cw, output logic [3:0] dout,
                          output int corr_n, output int uncorr_n, output logic to);
    int waited;
    logic [7:0] es;
    int en;
    logic eg, sb, rb, to_c;
    logic [2:0] sy;
    to = 1'b0;
    loop_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waited = 0;
      while (!dec_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) to = 1'b1;
      tb_dec_in = cw[7 - i];
      tb_dec_valid = 1'b1;
      @(negedge clk);
    end
    tb_dec_valid = 1'b0;
    tb_dec_in = 1'b0;
    capture(-1, es, en, eg, dout, corr_n, uncorr_n, sy, to_c, sb, rb);
    to = to | to_c;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] es;
    int en, cn, un, exp_corr, exp_uncorr, sat_bad;
    logic eg, sb, rb, to;
    logic [3:0] dout;
    logic [2:0] sy;

    vecs[0] = '{4'b1011, 8'b0000_0000, 8'b0110_0110, 4'b1011, 3'd0, 0, 0};
    vecs[1] = '{4'b1011, 8'b0010_0000, 8'b0110_1110, 4'b1011, 3'd5, 1, 0};
    vecs[2] = '{4'b1011, 8'b0100_1000, 8'b0100_0010, 4'b0001, 3'd5, 0, 1};
    vecs[3] = '{4'b1011, 8'b0000_0001, 8'b0110_0111, 4'b1011, 3'd0, 1, 0};
    vecs[4] = '{4'b0000, 8'b0000_0000, 8'b0000_0000, 4'b0000, 3'd0, 0, 0};
    vecs[5] = '{4'b1111, 8'b1000_0000, 8'b1111_1101, 4'b1111, 3'd7, 1, 0};
    vecs[6] = '{4'b0001, 8'b0000_0010, 8'b0101_0010, 4'b0001, 3'd1, 1, 0};
    vecs[7] = '{4'b0001, 8'b0000_0110, 8'b0001_0010, 4'b0001, 3'd3, 0, 1};

    reset = 1'b1; enable = 1'b1; enc_in = 1'b0; enc_valid = 1'b0; inject_mask = '0;
    loop_sel = 1'b1; tb_dec_in = 1'b0; tb_dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_enc_ready", 32'(enc_ready), 32'd1);
    chk("rst_dec_ready", 32'(dec_ready), 32'd1);
    chk("rst_out_valids", {30'd0, enc_out_valid, dec_out_valid}, 32'd0);
    chk("rst_outs", {29'd0, enc_out, dec_out, err_corrected}, 32'd0);
    chk("rst_uncorr_flag", 32'(err_uncorrectable), 32'd0);
    chk("rst_syndrome", 32'(syndrome), 32'd0);
    chk("rst_counters", {16'd0, corr_cnt, uncorr_cnt}, 32'd0);

    exp_corr = 0;
    exp_uncorr = 0;
    for (int v = 0; v < 8; v++) begin
      run_word(vecs[v].data, vecs[v].mask, -1, es, en, eg, dout, cn, un, sy, to, sb, rb);
      exp_corr += vecs[v].corr;
      exp_uncorr += vecs[v].uncorr;
      chk($sformatf("v%0d_timeout", v), 32'(to), 32'd0);
      chk($sformatf("v%0d_enc_seq", v), 32'(es), 32'(vecs[v].enc));
      chk($sformatf("v%0d_enc_len", v), 32'(en), 32'd8);
      chk($sformatf("v%0d_enc_gap", v), {31'd0, eg}, 32'd0);
      chk($sformatf("v%0d_enc_ready_in_shift", v), {31'd0, rb}, 32'd0);
      chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vecs[v].dout));
      chk($sformatf("v%0d_syndrome", v), 32'(sy), 32'(vecs[v].syn));
      chk($sformatf("v%0d_corr_pulses", v), 32'(cn), 32'(vecs[v].corr));
      chk($sformatf("v%0d_uncorr_pulses", v), 32'(un), 32'(vecs[v].uncorr));
      chk($sformatf("v%0d_corr_cnt", v), 32'(corr_cnt), 32'(exp_corr));
      chk($sformatf("v%0d_uncorr_cnt", v), 32'(uncorr_cnt), 32'(exp_uncorr));
    end

    // Reset mid-codeword after two decoder bits.
    loop_sel = 1'b0;
    tb_dec_valid = 1'b1;
    tb_dec_in = 1'b1;
    @(negedge clk);
    tb_dec_in = 1'b0;
    @(negedge clk);
    tb_dec_valid = 1'b0;
    chk("partial_dec_ready", 32'(dec_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset_dec_ready", 32'(dec_ready), 32'd1);
    chk("post_reset_counters", {16'd0, corr_cnt, uncorr_cnt}, 32'd0);
    dec_word(8'b0110_0110, dout, cn, un, to);
    chk("post_reset_timeout", 32'(to), 32'd0);
    chk("post_reset_dout", 32'(dout), 32'b1011);
    chk("post_reset_flags", 32'(cn + un), 32'd0);

    // Stall for three cycles after three codeword bits have gone out.
    run_word(4'b1011, 8'b0000_0000, 3, es, en, eg, dout, cn, un, sy, to, sb, rb);
    chk("stall_timeout", 32'(to), 32'd0);
    chk("stall_outputs_quiet", {31'd0, sb}, 32'd0);
    chk("stall_enc_seq", 32'(es), 32'b0110_0110);
    chk("stall_enc_len", 32'(en), 32'd8);
    chk("stall_dout", 32'(dout), 32'b1011);
    chk("stall_flags", 32'(cn + un), 32'd0);

    // Counter saturation with one correctable error per word.
    sat_bad = 0;
    for (int w = 0; w < 258; w++) begin
      run_word(4'b1011, 8'b0010_0000, -1, es, en, eg, dout, cn, un, sy, to, sb, rb);
      if (to || dout != 4'b1011 || cn != 1) sat_bad++;
      if (w == 253) chk("sat_corr_cnt_254", 32'(corr_cnt), 32'd254);
    end
    chk("sat_word_errors", 32'(sat_bad), 32'd0);
    chk("sat_corr_cnt", 32'(corr_cnt), 32'd255);
    chk("sat_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
